// File: rtl/mmio_timer_pkg.sv
// Shared types and constants for the mmio_timer time base.
// Register offsets, CTRL bit positions and reset values.
package timer_pkg;

  typedef enum logic [1:0] {
    OFF_MILLIS = 2'd0,
    OFF_MICROS = 2'd1,
    OFF_CMP    = 2'd2,
    OFF_CTRL   = 2'd3
  } off_t;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_MF = 2;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;
  localparam int US_PER_MS = 1000;

  typedef struct packed {
    logic mf;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    return {29'd0, c};
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Word-wide load/store port of the timer window.
// Same timing as data memory: one-cycle registered read data.
interface mmio_timer_if;
  logic        sel;
  logic        wren;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, wren, addr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, wren, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_timer_tick.sv
// Modulo-N event counter; tick is high on the terminal count while en.
// clr restarts the count and takes priority over counting.
module tick_prescaler #(
  parameter int MODULUS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(MODULUS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped us/ms time base with ms compare and sticky match flag.
// Define TIMER_SNAPSHOT_EN for a coherent MICROS-then-MILLIS read pair.
module mmio_timer
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000
) (
  input  logic         clk,
  input  logic         reset_n,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  localparam int US_DIV = CLK_FREQ_HZ / 1000000;

  generate
    if (CLK_FREQ_HZ <= 0 || (CLK_FREQ_HZ % 1000000) != 0) begin : g_bad_freq
      $error("mmio_timer: CLK_FREQ_HZ must be a nonzero multiple of 1 MHz");
    end
  endgenerate

  logic [31:0] millis;
  logic [31:0] micros;
  logic [31:0] cmp;
  ctrl_t       ctrl;
  logic [31:0] rdata_q;
  logic [31:0] rdata_nxt;
  logic [31:0] millis_rd;
  logic        us_tick;
  logic        ms_tick;
  logic        match;
  logic        rd;
  logic        wr;
  off_t        off;

  assign off = off_t'(bus.addr);
  assign rd  = bus.sel & ~bus.wren;
  assign wr  = bus.sel & bus.wren;

  logic wr_millis;
  logic wr_micros;
  logic wr_cmp;
  logic wr_ctrl;

  assign wr_millis = wr && (off == OFF_MILLIS);
  assign wr_micros = wr && (off == OFF_MICROS);
  assign wr_cmp    = wr && (off == OFF_CMP);
  assign wr_ctrl   = wr && (off == OFF_CTRL);

  tick_prescaler #(
    .MODULUS (US_DIV)
  ) u_us_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .clr     (wr_micros),
    .tick    (us_tick)
  );

  tick_prescaler #(
    .MODULUS (US_PER_MS)
  ) u_ms_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (us_tick),
    .clr     (wr_millis | wr_micros),
    .tick    (ms_tick)
  );

  // A register write always beats a same-cycle tick on that register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      millis <= '0;
      micros <= '0;
    end else begin
      if (wr_millis) begin
        millis <= bus.wdata;
      end else if (ms_tick) begin
        millis <= millis + 32'd1;
      end
      if (wr_micros) begin
        micros <= bus.wdata;
      end else if (us_tick) begin
        micros <= micros + 32'd1;
      end
    end
  end

  assign match = ctrl.en && (millis == cmp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp  <= CMP_RESET;
      ctrl <= '0;
    end else begin
      if (wr_cmp) begin
        cmp <= bus.wdata;
      end
      if (wr_ctrl) begin
        ctrl.en <= bus.wdata[CTRL_EN];
        ctrl.ie <= bus.wdata[CTRL_IE];
      end
      ctrl.mf <= match |
        (ctrl.mf & ~(wr_ctrl & bus.wdata[CTRL_MF]));
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] shadow;
  logic        shadow_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      shadow_v <= 1'b0;
    end else if (rd && off == OFF_MICROS) begin
      shadow   <= millis;
      shadow_v <= 1'b1;
    end else if (rd && off == OFF_MILLIS) begin
      shadow_v <= 1'b0;
    end
  end

  assign millis_rd = shadow_v ? shadow : millis;
`else
  assign millis_rd = millis;
`endif

  always_comb begin
    rdata_nxt = millis_rd;
    unique case (off)
      OFF_MILLIS: rdata_nxt = millis_rd;
      OFF_MICROS: rdata_nxt = micros;
      OFF_CMP:    rdata_nxt = cmp;
      OFF_CTRL:   rdata_nxt = ctrl_word(ctrl);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd) begin
      rdata_q <= rdata_nxt;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = ctrl.mf & ctrl.ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Randomised self-checking bench for mmio_timer at 2 MHz (2 clocks/us).
// Reference model derives counters from elapsed edges since the last load.
module tb_mmio_timer;

  localparam int D = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(
    .CLK_FREQ_HZ (2000000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each counter is a base value plus ticks elapsed since its epoch.
  longint      cyc;
  longint      us_e;
  longint      ms_m;
  logic [31:0] us_v;
  logic [31:0] ms_w;
  logic [31:0] m_cmp;
  logic        m_en;
  logic        m_ie;
  logic        m_flag;
  logic [31:0] exp_rdata;
  logic        exp_irq;
`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] m_shadow;
  logic        m_shadow_v;
`endif

  function automatic longint ut(longint n);
    return (n - us_e) / D;
  endfunction

  function automatic logic [31:0] mic(longint n);
    return us_v + 32'(ut(n));
  endfunction

  function automatic logic [31:0] mil(longint n);
    return ms_w + 32'((ut(n) - ut(ms_m)) / 1000);
  endfunction

  task automatic model_reset();
    cyc = 0;
    us_e = 0;
    ms_m = 0;
    us_v = '0;
    ms_w = '0;
    m_cmp = 32'hFFFF_FFFF;
    m_en = 1'b0;
    m_ie = 1'b0;
    m_flag = 1'b0;
    exp_rdata = '0;
    exp_irq = 1'b0;
`ifdef TIMER_SNAPSHOT_EN
    m_shadow = '0;
    m_shadow_v = 1'b0;
`endif
  endtask

  task automatic model_step();
    longint n;
    logic [31:0] mil_pre;
    logic [31:0] mic_pre;
    logic [31:0] mnew;
    logic match;
    n = cyc + 1;
    mil_pre = mil(cyc);
    mic_pre = mic(cyc);
    match = m_en && (mil_pre == m_cmp);
    if (bus.sel && !bus.wren) begin
      case (bus.addr)
        2'd0: begin
          exp_rdata = mil_pre;
`ifdef TIMER_SNAPSHOT_EN
          if (m_shadow_v) exp_rdata = m_shadow;
          m_shadow_v = 1'b0;
`endif
        end
        2'd1: begin
          exp_rdata = mic_pre;
`ifdef TIMER_SNAPSHOT_EN
          m_shadow = mil_pre;
          m_shadow_v = 1'b1;
`endif
        end
        2'd2: exp_rdata = m_cmp;
        default: exp_rdata = {29'd0, m_flag, m_ie, m_en};
      endcase
    end
    if (bus.sel && bus.wren) begin
      case (bus.addr)
        2'd0: begin
          ms_m = n;
          ms_w = bus.wdata;
        end
        2'd1: begin
          mnew = mil(n);
          us_e = n;
          us_v = bus.wdata;
          ms_m = n;
          ms_w = mnew;
        end
        2'd2: m_cmp = bus.wdata;
        default: begin
          m_en = bus.wdata[0];
          m_ie = bus.wdata[1];
          if (bus.wdata[2]) m_flag = 1'b0;
        end
      endcase
    end
    if (match) m_flag = 1'b1;
    cyc = n;
    exp_irq = m_flag & m_ie;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(logic s, logic w, logic [1:0] a, logic [31:0] d);
    bus.sel = s;
    bus.wren = w;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.sel = 1'b0;
    bus.wren = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(logic [1:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle_until(longint target);
    while (cyc < target) idle();
  endtask

  task automatic timeout(string name, logic ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: wait bound expired, got 0 required 1", name);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("rdata", bus.rdata, exp_rdata);
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  initial begin
    int r;
    logic [1:0] ra;
    bus.sel = 1'b0;
    bus.wren = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    #2;
    reset_n = 1'b1;

    idle_until(20);
    rd(2'd1);
    chk("micros_20", bus.rdata, 32'd10);
    rd(2'd0);
    chk("millis_0", bus.rdata, 32'd0);
    rd(2'd2);
    chk("cmp_reset", bus.rdata, 32'hFFFF_FFFF);
    rd(2'd3);
    chk("ctrl_reset", bus.rdata, 32'd0);

    idle_until(1999);
    rd(2'd0);
    chk("millis_1999", bus.rdata, 32'd0);
    rd(2'd1);
    chk("micros_2000", bus.rdata, 32'd1000);
    rd(2'd0);
    chk("millis_2001", bus.rdata, 32'd1);

    wr(2'd1, 32'hFFFF_FFFE);
    repeat (4) idle();
    rd(2'd1);
    chk("micros_wrap", bus.rdata, 32'd0);
    chk("wrap_irq", {31'd0, irq}, 32'd0);

    wr(2'd0, 32'd2);
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd3);
    for (int k = 0; k < 5000 && mil(cyc) != 32'd3; k++) idle();
    timeout("reach_ms3", mil(cyc) == 32'd3);
    chk("irq_at_ms3", {31'd0, irq}, 32'd0);
    idle();
    chk("irq_after_ms3", {31'd0, irq}, 32'd1);
    for (int k = 0; k < 5000 && mil(cyc) != 32'd4; k++) idle();
    timeout("reach_ms4", mil(cyc) == 32'd4);
    chk("flag_sticky", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'd7);
    chk("w1c_clear", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'd4);
    chk("cmp4_next", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'd7);
    chk("set_beats_w1c", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'd2);
    chk("disable_keeps", {31'd0, irq}, 32'd1);
    rd(2'd3);
    chk("ctrl_read", bus.rdata, 32'd6);
    wr(2'd3, 32'd6);
    chk("w1c_disabled", {31'd0, irq}, 32'd0);

    for (int k = 0; k < 5000 && mil(cyc + 1) == mil(cyc); k++) idle();
    timeout("find_ms_tick", mil(cyc + 1) != mil(cyc));
    wr(2'd0, 32'd5);
    rd(2'd0);
    chk("write_beats_tick", bus.rdata, 32'd5);

    wr(2'd2, 32'd5);
    wr(2'd3, 32'd3);
    idle();
    rd(2'd0);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rdata", bus.rdata, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    rd(2'd1);
    chk("post_reset_micros", bus.rdata, 32'd0);
    rd(2'd0);
    chk("post_reset_millis", bus.rdata, 32'd0);
    rd(2'd3);
    chk("post_reset_ctrl", bus.rdata, 32'd0);

    idle_until(1998);
    rd(2'd1);
    chk("snap_micros", bus.rdata, 32'd999);
    idle_until(2002);
    rd(2'd0);
`ifdef TIMER_SNAPSHOT_EN
    chk("snap_shadow", bus.rdata, 32'd0);
`else
    chk("snap_live", bus.rdata, 32'd1);
`endif
    rd(2'd0);
    chk("snap_second", bus.rdata, 32'd1);

    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 99));
      ra = 2'($urandom_range(0, 3));
      if (r < 45) idle();
      else if (r < 82) rd(ra);
      else if (r < 88) wr(2'd2, mil(cyc) + 32'($urandom_range(0, 2)));
      else if (r < 92) wr(2'd3, 32'($urandom_range(0, 7)));
      else if (r < 95) wr(2'd0, 32'hFFFF_FFF0 + 32'($urandom_range(0, 31)));
      else if (r < 98) wr(2'd1, 32'hFFFF_FFF0 + 32'($urandom_range(0, 31)));
      else wr(2'd2, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
Memory-mapped free-running time base that sits beside the data memory on the core's load/store path. Its read data is muxed into the data-memory read path, so it feeds the load result.
- Provides a microsecond counter, a millisecond counter and a millisecond compare with a sticky match flag.
- Firmware uses it for delays and LED/RGB blink timing.
- Bus timing matches data memory: synchronous, one-cycle read latency, word access only.

Parameters:
- CLK_FREQ_HZ, 12000000: core clock frequency. Must be a nonzero multiple of 1000000; elaboration fails otherwise.
- US_DIV, CLK_FREQ_HZ/1000000: derived clocks per microsecond; not overridden independently.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- sel  input  1  chip select: address decoded to the timer window this cycle
- wren  input  1  write strobe, qualified by sel
- addr  input  2  word offset: 0 MILLIS, 1 MICROS, 2 CMP, 3 CTRL
- wdata  input  32  write data, full word only
- rdata  output  32  registered read data
- irq  output  1  level interrupt = match_flag & irq_en

Behaviour:
- Reset (async assert, sync release):
  - rdata=0; irq=0; millis=0; micros=0.
  - Both prescalers=0; cmp=32'hFFFF_FFFF; CTRL enable=0, irq_en=0, match_flag=0.
- Microsecond prescaler:
  - Counts 0..US_DIV-1, always running.
  - us_tick is a one-cycle pulse on the terminal count.
  - On us_tick, micros increments modulo 2^32; wrap 0xFFFF_FFFF->0 with no flag.
- Millisecond prescaler:
  - Counts us_ticks 0..999.
  - ms_tick fires in the same cycle as the us_tick that hits 999.
  - On ms_tick, millis increments modulo 2^32.
- Reads (sel & ~wren):
  - rdata is loaded at the next edge with the addressed register's pre-edge value; 1-cycle latency.
  - rdata holds its value when not reading.
  - CTRL read format: bit0 enable, bit1 irq_en, bit2 match_flag, bits[31:3]=0.
- Writes (sel & wren):
  - MILLIS: load wdata and clear the ms prescaler.
  - MICROS: load wdata and clear both prescalers.
  - CMP: load wdata.
  - CTRL: bit0/bit1 written directly; bit2 is write-1-to-clear.
- Write vs tick in the same cycle: the write wins and the increment is dropped.
- Compare:
  - When enable=1 and millis==cmp (combinational, post-update value), match_flag sets next cycle.
  - match_flag is sticky until W1C.
  - Set and W1C in the same cycle: set wins.
  - Disabling enable does not clear the flag.
- Reset mid-read: rdata forced to 0; the pending read is lost.

Optional Feature:
- Macro TIMER_SNAPSHOT_EN.
- Defined:
  - A read of MICROS also latches millis into a 32-bit shadow in the same edge.
  - The next MILLIS read returns the shadow, giving a coherent pair, then the shadow is invalidated.
  - Subsequent MILLIS reads return the live value.
- Undefined: no shadow; MILLIS reads always return the live value.

Decomposition:
- Package timer_pkg:
  - Address offset enum (OFF_MILLIS, OFF_MICROS, OFF_CMP, OFF_CTRL).
  - CTRL bit-index constants.
  - CMP_RESET = 32'hFFFF_FFFF.
  - US_PER_MS = 1000.
- Sub-module tick_prescaler:
  - Parameter MODULUS; inputs clk, reset_n, en, clr; output tick.
  - Instantiated twice: the microsecond stage with en=1, the millisecond stage with en=us_tick.

Test Plan:
- Bench uses CLK_FREQ_HZ=2000000 (US_DIV=2).
- Release reset, read MICROS after 20 clocks -> rdata=10 one cycle after the read strobe. MILLIS=0; CMP reads 0xFFFF_FFFF.
- Run 2000 clocks after reset -> MILLIS=1 and MICROS=1000, exactly at edge 2000.
- Write MICROS=0xFFFF_FFFE, wait 4 clocks -> MICROS=0 (wrap). No irq.
- Write CMP=3, CTRL=0b011, run to millis=3:
  - match_flag=1 and irq=1 one cycle after millis==3.
  - Write CTRL=0b111 at a non-matching time -> flag clears, irq=0.
  - W1C in the match cycle -> flag stays 1.
- Write MILLIS=5 in the same cycle as an ms_tick -> MILLIS reads 5, not 6.
- Assert reset_n=0 mid-count, then release -> all counters 0, rdata=0, irq=0 immediately (async).
- With TIMER_SNAPSHOT_EN: read MICROS at 999 us, wait past the ms boundary, read MILLIS -> 0 (shadow). A second MILLIS read -> 1.
